// File: rtl/peak_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// peak_scan_ctrl_if
// Bundles the two buses of the peak-scan sequencer:
//   RAM read port : ram_rd_en, ram_rd_addr[13:0] ({bin, index}), ram_rd_data[31:0]
//   Result stream : result_valid / result_ready handshake carrying
//                   result_bin[3:0], result_value[31:0], result_index[9:0]
// Optional (PEAK_SCAN_THRESHOLD_EN): threshold[31:0] in, result_hit out.
// Modports: master = sequencer side, slave = RAM / downstream side.
// ----------------------------------------------------------------------------
interface peak_scan_ctrl_if;
    logic        ram_rd_en;
    logic [13:0] ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_bin;
    logic [31:0] result_value;
    logic [9:0]  result_index;
`ifdef PEAK_SCAN_THRESHOLD_EN
    logic [31:0] threshold;
    logic        result_hit;

    modport master (
        output ram_rd_en, ram_rd_addr, result_valid, result_bin,
               result_value, result_index, result_hit,
        input  ram_rd_data, result_ready, threshold
    );
    modport slave (
        input  ram_rd_en, ram_rd_addr, result_valid, result_bin,
               result_value, result_index, result_hit,
        output ram_rd_data, result_ready, threshold
    );
`else
    modport master (
        output ram_rd_en, ram_rd_addr, result_valid, result_bin,
               result_value, result_index,
        input  ram_rd_data, result_ready
    );
    modport slave (
        input  ram_rd_en, ram_rd_addr, result_valid, result_bin,
               result_value, result_index,
        output ram_rd_data, result_ready
    );
`endif
endinterface

// File: rtl/peak_scan_ctrl.sv
// ----------------------------------------------------------------------------
// peak_scan_ctrl
// Range-bin peak search sequencer. On start it walks every range bin of the
// accumulated-spectrum RAM, reads indices SEARCH_START..1023 one per cycle,
// tracks the (first) maximum sample and its index while absorbing the RAM
// read latency, then offers one result per bin over a valid/ready handshake.
// After the last bin's result is accepted it pulses done.
//
// Ports:
//   clk   - single clock
//   rst   - synchronous active-high reset
//   start - one-cycle scan request, ignored while busy
//   busy  - scan in progress (cycle after accepted start through done cycle)
//   done  - one-cycle pulse after the last result is accepted
//   bus   - peak_scan_ctrl_if.master: RAM read port and result stream
//
// Optional feature macro: PEAK_SCAN_THRESHOLD_EN
//   Adds bus.threshold / bus.result_hit; results not above the threshold are
//   reported with value and index forced to zero.
// ----------------------------------------------------------------------------
module peak_scan_ctrl #(
    parameter int TOTAL_RANGEBIN      = 9,
    parameter int POINTS_PER_RANGEBIN = 1024,
    parameter int SEARCH_START        = 512,
    parameter int RD_LATENCY          = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    peak_scan_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        OUT,
        FIN
    } state_t;

    localparam logic [9:0] START_IDX  = 10'(SEARCH_START);
    localparam logic [9:0] LAST_IDX   = 10'(POINTS_PER_RANGEBIN - 1);
    localparam logic [3:0] LAST_BIN   = 4'(TOTAL_RANGEBIN - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  bin_q;
    logic [9:0]  idx_q;
    logic [31:0] max_q;
    logic [9:0]  max_idx_q;
    logic [1:0]  drain_cnt_q;

    // Read-latency alignment: valid flag and index of each outstanding read.
    logic        vld_pipe_q [RD_LATENCY];
    logic [9:0]  idx_pipe_q [RD_LATENCY];

    // Control strobes from the FSM.
    logic rd_en;
    logic scan_init;   // start accepted: clear bin and per-bin search state
    logic next_bin;    // handshake on a non-final bin: advance bin

    // ------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        rd_en            = 1'b0;
        scan_init        = 1'b0;
        next_bin         = 1'b0;
        done             = 1'b0;
        bus.result_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    scan_init = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                rd_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last read's data is compared in the final DRAIN cycle.
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) begin
                    if (bin_q == LAST_BIN) begin
                        state_d = FIN;
                    end else begin
                        next_bin = 1'b1;
                        state_d  = SCAN;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            idx_q       <= '0;
            max_q       <= '0;
            max_idx_q   <= '0;
            drain_cnt_q <= '0;
            // NOTE: the latency pipeline is cleared as well; a stale valid
            // bit surviving an abandoned scan would corrupt the next maximum.
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_pipe_q[i] <= 1'b0;
                idx_pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (scan_init) begin
                bin_q <= '0;
            end else if (next_bin) begin
                bin_q <= bin_q + 4'd1;
            end

            if (scan_init || next_bin) begin
                idx_q <= START_IDX;
            end else if (rd_en) begin
                idx_q <= idx_q + 10'd1;
            end

            if (state_q == DRAIN) begin
                drain_cnt_q <= drain_cnt_q + 2'd1;
            end else begin
                drain_cnt_q <= '0;
            end

            vld_pipe_q[0] <= rd_en;
            idx_pipe_q[0] <= idx_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                idx_pipe_q[i] <= idx_pipe_q[i-1];
            end

            // Strict compare keeps the first occurrence on ties. The
            // pipeline is empty whenever a new bin is initialised.
            if (scan_init || next_bin) begin
                max_q     <= '0;
                max_idx_q <= START_IDX;
            end else if (vld_pipe_q[RD_LATENCY-1] && (bus.ram_rd_data > max_q)) begin
                max_q     <= bus.ram_rd_data;
                max_idx_q <= idx_pipe_q[RD_LATENCY-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy            = (state_q != IDLE);
    assign bus.ram_rd_en   = rd_en;
    assign bus.ram_rd_addr = rd_en ? {bin_q, idx_q} : 14'd0;
    assign bus.result_bin  = bin_q;

`ifdef PEAK_SCAN_THRESHOLD_EN
    // Threshold is captured in the first OUT cycle and held for the rest of
    // that OUT state so the presented result cannot change while stalled.
    logic        out_seen_q;
    logic [31:0] thr_q;
    logic        first_out;
    logic [31:0] thr_eff;
    logic        hit;

    assign first_out = (state_q == OUT) && !out_seen_q;
    assign thr_eff   = first_out ? bus.threshold : thr_q;
    assign hit       = (max_q > thr_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_seen_q <= 1'b0;
            thr_q      <= '0;
        end else begin
            out_seen_q <= (state_q == OUT);
            if (first_out) begin
                thr_q <= bus.threshold;
            end
        end
    end

    assign bus.result_hit   = hit;
    assign bus.result_value = hit ? max_q : 32'd0;
    assign bus.result_index = hit ? max_idx_q : 10'd0;
`else
    assign bus.result_value = max_q;
    assign bus.result_index = max_idx_q;
`endif

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_peak_scan_ctrl
// Directed bench for peak_scan_ctrl with default parameters. A behavioural
// RAM with RD_LATENCY-cycle read delay serves per-bin data patterns; results
// are captured at handshakes and compared against hand-computed peaks.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_peak_scan_ctrl;

    localparam int RL        = 2;
    localparam int NBINS     = 9;
    localparam int SSTART    = 512;
    localparam int BIN_CYC   = (1024 - SSTART) + RL + 1;   // 515
    localparam int DONE_CYC  = NBINS * BIN_CYC + 1;         // 4636

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    peak_scan_ctrl_if bus ();

    peak_scan_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef PEAK_SCAN_THRESHOLD_EN
    assign bus.threshold = 32'd0;
`endif

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- RAM model ----------------
    int mode = 0;

    function automatic logic [31:0] sample(input int md, input logic [3:0] b, input logic [9:0] i);
        logic [31:0] v;
        v = (i == 10'd700) ? 32'(100 + int'(b)) : 32'd0;
        if (md == 1) begin
            case (b)
                4'd0: v = {22'd0, i};
                4'd1: v = (i == 10'd600 || i == 10'd900) ? 32'd50 :
                          (i == 10'd100) ? 32'd999 : 32'd0;
                4'd2: v = 32'd0;
                4'd3: v = (i == 10'd512) ? 32'd7 : 32'd0;
                4'd4: v = (i == 10'd513) ? 32'hFFFF_FFFF :
                          (i == 10'd514) ? 32'h8000_0000 : 32'd0;
                default: ;
            endcase
        end
        return v;
    endfunction

    logic [31:0] d_pipe [RL];
    always @(posedge clk) begin
        // Garbage on idle cycles: must never be taken as a sample.
        d_pipe[0] <= bus.ram_rd_en ? sample(mode, bus.ram_rd_addr[13:10], bus.ram_rd_addr[9:0])
                                   : 32'hFFFF_FFF0;
        for (int i = 1; i < RL; i++) d_pipe[i] <= d_pipe[i-1];
    end
    assign bus.ram_rd_data = d_pipe[RL-1];

    // ---------------- monitors ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  res_bin [64];
    logic [31:0] res_val [64];
    logic [9:0]  res_idx [64];
    int res_n      = 0;
    int done_count = 0;
    int rd_count   = 0;
    int addr_bad   = 0;
    int hs_cycle [16];
    int rd_first [16];

    bit          bp_en = 1'b0;
    int          stall_n = 0;
    int          stall_bad = 0;
    logic [31:0] snap_val;
    logic [9:0]  snap_idx;

    initial bus.result_ready = 1'b1;

    always @(negedge clk) begin
        // Backpressure at bin 3: hold ready low for 20 OUT cycles.
        if (bp_en && bus.result_valid && bus.result_bin == 4'd3 && stall_n < 20) begin
            if (stall_n == 0) begin
                snap_val = bus.result_value;
                snap_idx = bus.result_index;
            end else if (bus.result_value !== snap_val || bus.result_index !== snap_idx) begin
                stall_bad++;
            end
            if (bus.ram_rd_en !== 1'b0) stall_bad++;
            bus.result_ready = 1'b0;
            stall_n++;
        end else begin
            bus.result_ready = 1'b1;
        end

        if (!rst) begin
            if (bus.result_valid && bus.result_ready && res_n < 64) begin
                res_bin[res_n] = bus.result_bin;
                res_val[res_n] = bus.result_value;
                res_idx[res_n] = bus.result_index;
                hs_cycle[bus.result_bin] = cyc;
                res_n++;
            end
            if (done) done_count++;
            if (bus.ram_rd_en) begin
                rd_count++;
                if (int'(bus.ram_rd_addr[9:0]) < SSTART) addr_bad++;
                if (bus.ram_rd_addr[9:0] == 10'd512) rd_first[bus.ram_rd_addr[13:10]] = cyc;
            end
        end
    end

    // ---------------- scan driver ----------------
    int   t_done, t_first_valid;
    logic t_busy1, t_rden1;
    logic [13:0] t_addr1;

    task automatic run_scan(input bit poke_start);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        t_done = -1;
        t_first_valid = -1;
        while (n < 8000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                t_busy1 = busy;
                t_rden1 = bus.ram_rd_en;
                t_addr1 = bus.ram_rd_addr;
            end
            if (poke_start && n == 100) start = 1'b1;
            if (n == 101) start = 1'b0;
            if (t_first_valid < 0 && bus.result_valid) t_first_valid = n;
            if (done) begin
                t_done = n;
                break;
            end
        end
        if (t_done < 0) check("scan timeout", 64'(n), 64'(DONE_CYC));
    endtask

    function automatic logic [31:0] exp_val(input int md, input int b);
        if (md == 1) begin
            case (b)
                0: return 32'd1023;
                1: return 32'd50;
                2: return 32'd0;
                3: return 32'd7;
                4: return 32'hFFFF_FFFF;
                default: ;
            endcase
        end
        return 32'(100 + b);
    endfunction

    function automatic logic [9:0] exp_idx(input int md, input int b);
        if (md == 1) begin
            case (b)
                0: return 10'd1023;
                1: return 10'd600;
                2: return 10'd512;
                3: return 10'd512;
                4: return 10'd513;
                default: ;
            endcase
        end
        return 10'd700;
    endfunction

    task automatic check_results(input string name, input int base, input int md);
        check({name, " count"}, 64'(res_n - base), 64'(NBINS));
        for (int b = 0; b < NBINS; b++) begin
            check($sformatf("%s bin%0d bin", name, b),   64'(res_bin[base+b]), 64'(b));
            check($sformatf("%s bin%0d value", name, b), 64'(res_val[base+b]), 64'(exp_val(md, b)));
            check($sformatf("%s bin%0d index", name, b), 64'(res_idx[base+b]), 64'(exp_idx(md, b)));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " busy"},         64'(busy), 64'd0);
        check({name, " done"},         64'(done), 64'd0);
        check({name, " ram_rd_en"},    64'(bus.ram_rd_en), 64'd0);
        check({name, " ram_rd_addr"},  64'(bus.ram_rd_addr), 64'd0);
        check({name, " result_valid"}, 64'(bus.result_valid), 64'd0);
        check({name, " result_bin"},   64'(bus.result_bin), 64'd0);
        check({name, " result_value"}, 64'(bus.result_value), 64'd0);
        check({name, " result_index"}, 64'(bus.result_index), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base, dbase, rbase, n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: one peak per bin, ready high, extra start mid-scan ignored.
        mode  = 0;
        base  = res_n;
        dbase = done_count;
        rbase = rd_count;
        run_scan(1'b1);
        check("t1 busy at T+1",     64'(t_busy1), 64'd1);
        check("t1 rd_en at T+1",    64'(t_rden1), 64'd1);
        check("t1 addr at T+1",     64'(t_addr1), 64'h200);
        check("t1 first valid",     64'(t_first_valid), 64'(BIN_CYC));
        check("t1 done cycle",      64'(t_done), 64'(DONE_CYC));
        check_results("t1", base, 0);
        check("t1 read count",      64'(rd_count - rbase), 64'(NBINS * 512));
        check("t1 reads outside window", 64'(addr_bad), 64'd0);
        @(negedge clk);
        check("t1 busy after done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("t1 done pulses",     64'(done_count - dbase), 64'd1);

        // 2: ramp, tie, all-zero, window edge, unsigned compare.
        mode = 1;
        base = res_n;
        run_scan(1'b0);
        check("t2 done cycle", 64'(t_done), 64'(DONE_CYC));
        check_results("t2", base, 1);
        check("t2 reads outside window", 64'(addr_bad), 64'd0);
        repeat (3) @(negedge clk);

        // 3: backpressure on bin 3.
        mode  = 0;
        base  = res_n;
        bp_en = 1'b1;
        run_scan(1'b0);
        bp_en = 1'b0;
        check("t3 done cycle",     64'(t_done), 64'(DONE_CYC + 20));
        check_results("t3", base, 0);
        check("t3 stall cycles",   64'(stall_n), 64'd20);
        check("t3 stall stability/no reads", 64'(stall_bad), 64'd0);
        check("t3 resume cycle",   64'(rd_first[4]), 64'(hs_cycle[3] + 1));
        repeat (3) @(negedge clk);

        // 4: reset in the middle of bin 4's scan.
        dbase = done_count;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 6000 && !(bus.ram_rd_en && bus.ram_rd_addr[13:10] == 4'd4 &&
                             bus.ram_rd_addr[9:0] == 10'd700)) begin
            @(negedge clk);
            n++;
        end
        check("t4 reached bin 4", 64'(n < 6000), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t4 reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t4 no done after reset", 64'(done_count - dbase), 64'd0);
        check("t4 idle after reset",    64'(busy), 64'd0);

        // 5: fresh full scan after the abandoned one.
        base = res_n;
        run_scan(1'b0);
        check("t5 done cycle", 64'(t_done), 64'(DONE_CYC));
        check_results("t5", base, 0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
